// File: rtl/sha1_pkg.sv
// sha1_pkg: SHA-1 constants, FSM state encoding and per-round helper functions
package sha1_pkg;
  localparam logic [159:0] SHA1_IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [31:0] K0 = 32'h5a827999;
  localparam logic [31:0] K1 = 32'h6ed9eba1;
  localparam logic [31:0] K2 = 32'h8f1bbcdc;
  localparam logic [31:0] K3 = 32'hca62c1d6;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] FINAL = 2'd3;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] f_sel(input logic [6:0] t, input logic [31:0] b, input logic [31:0] c,
                                        input logic [31:0] d);
    return t < 7'd20 ? (b & c) | (~b & d) :
           t < 7'd40 ? b ^ c ^ d :
           t < 7'd60 ? (b & c) | (b & d) | (c & d) : b ^ c ^ d;
  endfunction

  function automatic logic [31:0] k_sel(input logic [6:0] t);
    return t < 7'd20 ? K0 : t < 7'd40 ? K1 : t < 7'd60 ? K2 : K3;
  endfunction
endpackage

// File: rtl/sha1_round.sv
// sha1_round: one combinational SHA-1 round on the packed working state {A,B,C,D,E}
module sha1_round
  import sha1_pkg::*;
(
  input  logic [159:0] s_i,
  input  logic [31:0]  w_i,
  input  logic [6:0]   t_i,
  output logic [159:0] s_o
);
  logic [31:0] a, b, c, d, e, tmp;
  assign {a, b, c, d, e} = s_i;
  assign tmp = rotl(a, 5) + f_sel(t_i, b, c, d) + e + k_sel(t_i) + w_i;
  assign s_o = {tmp, a, rotl(b, 30), c, d};
endmodule

// File: rtl/sha1_stream.sv
// sha1_stream: handshaked multi-block SHA-1 engine, UNROLL rounds per clock.
// Define SHA1_CMP_EN to add the iTarget/oMatch registered digest compare.
module sha1_stream
  import sha1_pkg::*;
#(
  parameter int UNROLL   = 1,
  parameter int WORDSIZE = 32,
  parameter int WORDNUM  = 16
) (
  input  logic                iClk,
  input  logic                reset,
  input  logic [WORDSIZE-1:0] iDat,
  input  logic                iValid,
  output logic                oReady,
  input  logic                iFirst,
  input  logic                iLast,
  output logic [159:0]        oDat,
  output logic                oValid,
`ifdef SHA1_CMP_EN
  input  logic [159:0]        iTarget,
  output logic                oMatch,
`endif
  output logic                oBusy
);
  if ((UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 5) || WORDSIZE != 32 || WORDNUM != 16)
  begin : g_bad_cfg
    $error("sha1_stream: UNROLL must be 1,2,4,5 and WORDSIZE/WORDNUM must be 32/16");
  end

  logic [1:0] state_q, state_d;
  logic [3:0] wcnt_q, wcnt_d;
  logic [6:0] rcnt_q, rcnt_d;
  logic [15:0][31:0] w_q, w_d;
  logic [15+UNROLL:0][31:0] ext;
  logic [159:0] h_q, h_d, s_q, s_d, h_sum, s_rnd;
  logic blk_last_q, blk_last_d, valid_q, valid_d, xfer;

  // Window holds W[rcnt..rcnt+15]; the words past it are generated here and may chain within a cycle.
  function automatic logic [15+UNROLL:0][31:0] expand(input logic [15:0][31:0] w);
    logic [15+UNROLL:0][31:0] x;
    x[15:0] = w;
    for (int j = 0; j < UNROLL; j++) x[16+j] = rotl(x[13+j] ^ x[8+j] ^ x[2+j] ^ x[j], 1);
    return x;
  endfunction

  assign ext = expand(w_q);

  for (genvar r = 0; r < UNROLL; r++) begin : g_rnd
    logic [159:0] si, so;
    if (r == 0) begin : g_head
      assign si = s_q;
    end else begin : g_link
      assign si = g_rnd[r-1].so;
    end
    sha1_round u_round (.s_i(si), .w_i(ext[r]), .t_i(rcnt_q + 7'(r)), .s_o(so));
  end
  assign s_rnd = g_rnd[UNROLL-1].so;

  for (genvar i = 0; i < 5; i++) begin : g_sum
    assign h_sum[32*i +: 32] = h_q[32*i +: 32] + s_q[32*i +: 32];
  end

  assign oReady = state_q == IDLE || state_q == LOAD;
  assign oBusy  = state_q != IDLE;
  assign oDat   = h_q;
  assign oValid = valid_q;
  assign xfer   = iValid & oReady;

  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    w_d = w_q;
    h_d = h_q;
    s_d = s_q;
    blk_last_d = blk_last_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (xfer) begin
        w_d = {iDat, w_q[15:1]};
        blk_last_d = iLast;
        h_d = iFirst ? SHA1_IV : h_q;
        s_d = iFirst ? SHA1_IV : h_q;
        valid_d = 1'b0;
        wcnt_d = 4'd1;
        state_d = LOAD;
      end
      LOAD: if (xfer) begin
        w_d = {iDat, w_q[15:1]};
        wcnt_d = wcnt_q + 4'd1;
        rcnt_d = '0;
        state_d = wcnt_q == 4'd15 ? ROUND : LOAD;
      end
      ROUND: begin
        s_d = s_rnd;
        w_d = ext[15+UNROLL:UNROLL];
        rcnt_d = rcnt_q + 7'(UNROLL);
        state_d = rcnt_q == 7'(80 - UNROLL) ? FINAL : ROUND;
      end
      default: begin
        h_d = h_sum;
        valid_d = valid_q | blk_last_q;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      wcnt_q <= '0;
      rcnt_q <= '0;
      w_q <= '0;
      h_q <= SHA1_IV;
      s_q <= SHA1_IV;
      blk_last_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      rcnt_q <= rcnt_d;
      w_q <= w_d;
      h_q <= h_d;
      s_q <= s_d;
      blk_last_q <= blk_last_d;
      valid_q <= valid_d;
    end

`ifdef SHA1_CMP_EN
  logic match_q, match_d;
  assign match_d = state_q == IDLE && xfer ? 1'b0 :
                   state_q == FINAL && blk_last_q ? h_sum == iTarget : match_q;
  always_ff @(posedge iClk or posedge reset)
    if (reset) match_q <= 1'b0;
    else match_q <= match_d;
  assign oMatch = match_q;
`endif
endmodule

// File: tb/tb_sha1_stream.sv
// tb_sha1_stream: four engines (UNROLL 1,2,4,5) fed identical random-gap streams, scoreboarded against a SHA-1 model
module tb_sha1_stream;
  localparam logic [159:0] IVC = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] DIG_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] DIG_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] DIG_448 = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

  typedef struct {
    logic [159:0] dig;
    logic [159:0] tgt;
    int edg;
  } exp_t;

  logic iClk = 1'b0, reset = 1'b1, iValid = 1'b0, iFirst = 1'b0, iLast = 1'b0;
  logic [31:0] iDat = '0;
`ifdef SHA1_CMP_EN
  logic [159:0] iTarget = '0;
`endif
  exp_t sbq[4][$];
  logic [7:0] mb[$];
  logic [31:0] mw[$];
  int cyc = 0, nassert = 0, nfail = 0, last_edge = 0;
  event rst_ev;
  logic all_rdy;

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    nassert++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    nassert++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  for (genvar k = 0; k < 4; k++) begin : g
    localparam int U = k == 0 ? 1 : k == 1 ? 2 : k == 2 ? 4 : 5;
    localparam int L = 80 / U + 1;
    logic [159:0] od;
    logic rd, vl, bs;
    int run = 0;
    logic pv = 1'b0;
    exp_t e;
`ifdef SHA1_CMP_EN
    logic mt;
`endif
    sha1_stream #(.UNROLL(U)) dut (
      .iClk(iClk), .reset(reset), .iDat(iDat), .iValid(iValid), .oReady(rd),
      .iFirst(iFirst), .iLast(iLast), .oDat(od), .oValid(vl),
`ifdef SHA1_CMP_EN
      .iTarget(iTarget), .oMatch(mt),
`endif
      .oBusy(bs)
    );

    initial forever begin
      @(negedge iClk);
      if (reset) begin
        run = 0;
        pv = 1'b0;
      end else begin
        if (!rd) run++;
        else if (run > 0) begin
          chk_i($sformatf("U%0d oReady-low run", U), run, L);
          run = 0;
        end
        if (vl && !pv) begin
          if (sbq[k].size() == 0) chk_i($sformatf("U%0d unexpected oValid", U), 1, 0);
          else begin
            e = sbq[k].pop_front();
            chk($sformatf("U%0d digest", U), od, e.dig);
            chk_i($sformatf("U%0d latency", U), cyc - e.edg, L);
`ifdef SHA1_CMP_EN
            chk($sformatf("U%0d oMatch", U), 160'(mt), 160'(e.dig == e.tgt));
`endif
          end
        end
`ifdef SHA1_CMP_EN
        if (!vl && pv) chk($sformatf("U%0d oMatch clear", U), 160'(mt), 160'(0));
`endif
        pv = vl;
      end
    end

    initial forever begin
      @(rst_ev);
      chk($sformatf("U%0d reset oDat", U), od, IVC);
      chk_i($sformatf("U%0d reset oValid", U), int'(vl), 0);
      chk_i($sformatf("U%0d reset oReady", U), int'(rd), 1);
      chk_i($sformatf("U%0d reset oBusy", U), int'(bs), 0);
`ifdef SHA1_CMP_EN
      chk_i($sformatf("U%0d reset oMatch", U), int'(mt), 0);
`endif
    end
  end

  assign all_rdy = g[0].rd & g[1].rd & g[2].rd & g[3].rd;

  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Textbook SHA-1 over the padded word stream in mw.
  function automatic logic [159:0] ref_sha1();
    logic [31:0] h[5];
    logic [31:0] x[80];
    logic [31:0] a, b, c, d, e, f, kk, t;
    h = '{32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, 32'hc3d2e1f0};
    for (int blk = 0; blk < mw.size() / 16; blk++) begin
      for (int i = 0; i < 80; i++)
        if (i < 16) x[i] = mw[blk*16+i];
        else x[i] = rl(x[i-3] ^ x[i-8] ^ x[i-14] ^ x[i-16], 1);
      {a, b, c, d, e} = {h[0], h[1], h[2], h[3], h[4]};
      for (int i = 0; i < 80; i++) begin
        if (i < 20) begin f = (b & c) | (~b & d); kk = 32'h5a827999; end
        else if (i < 40) begin f = b ^ c ^ d; kk = 32'h6ed9eba1; end
        else if (i < 60) begin f = (b & c) | (b & d) | (c & d); kk = 32'h8f1bbcdc; end
        else begin f = b ^ c ^ d; kk = 32'hca62c1d6; end
        t = rl(a, 5) + f + e + kk + x[i];
        e = d; d = c; c = rl(b, 30); b = a; a = t;
      end
      h[0] += a; h[1] += b; h[2] += c; h[3] += d; h[4] += e;
    end
    return {h[0], h[1], h[2], h[3], h[4]};
  endfunction

  function automatic void build_words();
    logic [7:0] p[$];
    logic [63:0] bits;
    p = mb;
    bits = 64'(mb.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    mw.delete();
    for (int i = 0; i < p.size(); i += 4) mw.push_back({p[i], p[i+1], p[i+2], p[i+3]});
  endfunction

  task automatic set_str(input string s);
    mb.delete();
    for (int i = 0; i < s.len(); i++) mb.push_back(s[i]);
    build_words();
  endtask

  task automatic set_rand(input int len);
    mb.delete();
    repeat (len) mb.push_back(8'($urandom));
    build_words();
  endtask

  task automatic wait_rdy();
    int n = 0;
    while (!all_rdy && n < 1000) begin
      @(negedge iClk);
      n++;
    end
    if (!all_rdy) chk_i("ready timeout", 0, 1);
  endtask

  task automatic send_block(input int b, input logic f, input logic l);
    for (int i = 0; i < 16; i++) begin
      @(negedge iClk);
      iValid = 1'b0;
      repeat ($urandom_range(0, 5)) @(negedge iClk);
      wait_rdy();
      iValid = 1'b1;
      iDat = mw[16*b+i];
      iFirst = i == 0 ? f : 1'($urandom);
      iLast = i == 0 ? l : 1'($urandom);
      if (i == 15) last_edge = cyc + 1;
      @(posedge iClk);
    end
    @(negedge iClk);
    iValid = 1'b0;
  endtask

  task automatic send_msg(input logic f, input logic [159:0] dig, input logic [159:0] tgt);
    exp_t e;
    int nb;
    nb = mw.size() / 16;
    wait_rdy();
`ifdef SHA1_CMP_EN
    iTarget = tgt;
`endif
    for (int b = 0; b < nb; b++) send_block(b, b == 0 ? f : 1'b0, b == nb - 1);
    e.dig = dig;
    e.tgt = tgt;
    e.edg = last_edge;
    for (int k = 0; k < 4; k++) sbq[k].push_back(e);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    @(negedge iClk);
    #2 reset = 1'b0;
    @(negedge iClk);
    ->rst_ev;
  endtask

  initial begin
    logic [159:0] dig, tgt;
    int n;
    repeat (2) @(negedge iClk);
    pulse_reset();
    set_str("abc");
    send_msg(1'b1, DIG_ABC, DIG_ABC);
    set_str("");
    send_msg(1'b1, DIG_EMPTY, ~DIG_EMPTY);
    set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(1'b1, DIG_448, DIG_448);
    set_rand($urandom_range(70, 120));
    wait_rdy();
    send_block(0, 1'b1, 1'b0);
    for (int r = 0; r < 6; r++) begin
      set_rand($urandom_range(0, 200));
      dig = ref_sha1();
      tgt = dig ^ (($urandom % 2) != 0 ? 160'(1) << $urandom_range(0, 159) : 160'(0));
      send_msg(1'b1, dig, tgt);
    end
    set_str("abc");
    wait_rdy();
    send_block(0, 1'b1, 1'b1);
    repeat (8) @(negedge iClk);
    pulse_reset();
    send_msg(1'b0, DIG_ABC, DIG_ABC ^ (160'(1) << 77));
    n = 0;
    while (sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size() > 0 && n < 2000) begin
      @(negedge iClk);
      n++;
    end
    chk_i("scoreboard drained", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);
    repeat (3) @(negedge iClk);
    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end
endmodule
